// File: rtl/modexp_param_pkg.sv
// Shared FSM state type and index-width helper for the modexp_param engine.
package modexp_param_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StScan,
      StSqr,
      StMul,
      StNext,
      StFin
   } state_e;

   // $clog2 with a floor of 1 so degenerate widths still give a legal vector.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/modexp_param_if.sv
// Request/result bundle between a modexp_param client (master) and the engine (slave).
interface modexp_param_if #(
   parameter int unsigned WIDTH     = 4096,
   parameter int unsigned EXP_WIDTH = WIDTH
);
   logic                 go;
   logic                 abort;
   logic [WIDTH-1:0]     message;
   logic [EXP_WIDTH-1:0] exponent;
   logic [WIDTH-1:0]     modulus;
   logic [WIDTH-1:0]     cypher;
   logic                 done;
   logic                 busy;
   logic                 err;

   modport master (
      output go, abort, message, exponent, modulus,
      input  cypher, done, busy, err
   );

   modport slave (
      input  go, abort, message, exponent, modulus,
      output cypher, done, busy, err
   );
endinterface

// File: rtl/modexp_param_modmul.sv
// Interleaved (Blakley) modular multiplier: p = a*b mod m, one bit of a per cycle, MSB first.
module modexp_param_modmul
   import modexp_param_pkg::*;
#(
   parameter int unsigned WIDTH = 4096
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] p_o,
   output logic             done_o
);
   localparam int unsigned CntW = idx_w(WIDTH + 1);

   logic [WIDTH-1:0] a_q, b_q, m_q, p_q, acc_q;
   logic [WIDTH+1:0] acc_d;
   logic [CntW-1:0]  cnt_q;
   logic             run_q, done_q;

   // Operands stay below m, so one conditional subtract after each step keeps acc < m.
   always_comb begin
      acc_d = {1'b0, acc_q, 1'b0};
      if (acc_d >= {2'b00, m_q}) acc_d = acc_d - {2'b00, m_q};
      if (a_q[WIDTH-1]) acc_d = acc_d + {2'b00, b_q};
      if (acc_d >= {2'b00, m_q}) acc_d = acc_d - {2'b00, m_q};
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         p_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         m_q    <= m_i;
         acc_q  <= '0;
         cnt_q  <= CntW'(WIDTH);
         run_q  <= 1'b1;
         done_q <= 1'b0;
      end else if (run_q) begin
         acc_q  <= acc_d[WIDTH-1:0];
         a_q    <= {a_q[WIDTH-2:0], 1'b0};
         cnt_q  <= cnt_q - CntW'(1);
         done_q <= (cnt_q == CntW'(1));
         if (cnt_q == CntW'(1)) begin
            run_q <= 1'b0;
            p_q   <= acc_d[WIDTH-1:0];
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign p_o    = p_q;
   assign done_o = done_q;

endmodule

// File: rtl/modexp_param.sv
// Modular exponentiation engine: cypher = message^exponent mod modulus, left-to-right binary.
module modexp_param
   import modexp_param_pkg::*;
#(
   parameter int unsigned WIDTH     = 4096,
   parameter int unsigned EXP_WIDTH = WIDTH
) (
   input  logic           clk_i,
   input  logic           reset_i,
   modexp_param_if.slave  bus
);
   localparam int unsigned IdxW = idx_w(EXP_WIDTH);

   state_e               state_q;
   logic                 go_q;
   logic [WIDTH-1:0]     msg_q, mod_q, r_q, cypher_q;
   logic [EXP_WIDTH-1:0] exp_q;
   logic [IdxW-1:0]      idx_q;
   logic                 done_q, busy_q, err_q;
   logic                 mm_start_q, mm_done;
   logic [WIDTH-1:0]     mm_b, mm_p;

   // Squaring feeds R on both inputs; multiplying feeds R and the base.
   assign mm_b = (state_q == StMul) ? msg_q : r_q;

   modexp_param_modmul #(
      .WIDTH (WIDTH)
   ) u_modmul (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start_i (mm_start_q),
      .a_i     (r_q),
      .b_i     (mm_b),
      .m_i     (mod_q),
      .p_o     (mm_p),
      .done_o  (mm_done)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         go_q       <= 1'b0;
         msg_q      <= '0;
         mod_q      <= '0;
         exp_q      <= '0;
         r_q        <= '0;
         idx_q      <= '0;
         cypher_q   <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         mm_start_q <= 1'b0;
      end else begin
         go_q       <= bus.go;
         mm_start_q <= 1'b0;
         if (bus.abort) begin
            if (state_q != StIdle) begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus.go && !go_q && !busy_q) begin
                     msg_q    <= bus.message;
                     exp_q    <= bus.exponent;
                     mod_q    <= bus.modulus;
                     done_q   <= 1'b0;
                     err_q    <= 1'b0;
                     cypher_q <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= StCheck;
                  end
               end
               StCheck: begin
                  if (mod_q < WIDTH'(2) || msg_q >= mod_q) begin
                     err_q    <= 1'b1;
                     cypher_q <= '0;
                     r_q      <= '0;
                     state_q  <= StFin;
                  end else if (exp_q == '0) begin
                     cypher_q <= WIDTH'(1);
                     r_q      <= WIDTH'(1);
                     state_q  <= StFin;
                  end else begin
                     idx_q   <= IdxW'(EXP_WIDTH - 1);
                     state_q <= StScan;
                  end
               end
               StScan: begin
                  if (exp_q[idx_q]) begin
                     r_q <= msg_q;
                     if (idx_q == '0) begin
                        state_q <= StFin;
                     end else begin
                        idx_q      <= idx_q - IdxW'(1);
                        mm_start_q <= 1'b1;
                        state_q    <= StSqr;
                     end
                  end else begin
                     idx_q <= idx_q - IdxW'(1);
                  end
               end
               // A done left over from an aborted run can coincide with our start pulse.
               StSqr: begin
                  if (mm_done && !mm_start_q) begin
                     r_q <= mm_p;
                     if (exp_q[idx_q]) begin
                        mm_start_q <= 1'b1;
                        state_q    <= StMul;
                     end else begin
                        state_q <= StNext;
                     end
                  end
               end
               StMul: begin
                  if (mm_done && !mm_start_q) begin
                     r_q     <= mm_p;
                     state_q <= StNext;
                  end
               end
               StNext: begin
                  if (idx_q == '0) begin
                     state_q <= StFin;
                  end else begin
                     idx_q      <= idx_q - IdxW'(1);
                     mm_start_q <= 1'b1;
                     state_q    <= StSqr;
                  end
               end
               StFin: begin
                  cypher_q <= r_q;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.cypher = cypher_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_modexp_param.sv
// Randomised self-checking bench for modexp_param: an 8-bit engine and a 32-bit/24-bit-exponent engine.
module tb_modexp_param;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   modexp_param_if #(.WIDTH(8),  .EXP_WIDTH(8))  bus8  ();
   modexp_param_if #(.WIDTH(32), .EXP_WIDTH(24)) bus32 ();

   modexp_param #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus8)
   );

   modexp_param #(.WIDTH(32), .EXP_WIDTH(24)) u_dut32 (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 64-bit square-and-multiply with the operand error rules.
   function automatic longint unsigned ref_pow(input longint unsigned b, input longint unsigned e,
                                               input longint unsigned m);
      longint unsigned r;
      if (m < 2 || b >= m) return 0;
      r = 1;
      b = b % m;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return r;
   endfunction

   // Edges from the first edge after go rises until done is seen high.
   function automatic int ref_lat(input longint unsigned b, input longint unsigned e,
                                  input longint unsigned m, input int w, input int ew);
      int msb, pop;
      if (m < 2 || b >= m || e == 0) return 3;
      msb = 0;
      pop = 0;
      for (int i = 0; i < ew; i++) begin
         if (e[i]) begin
            msb = i;
            pop++;
         end
      end
      return 4 + (ew - 1 - msb) + msb * (w + 3) + (pop - 1) * (w + 2);
   endfunction

   task automatic start8(input logic [7:0] msg, input logic [7:0] e, input logic [7:0] m);
      @(negedge clk);
      bus8.go = 1'b0;
      @(negedge clk);
      bus8.message  = msg;
      bus8.exponent = e;
      bus8.modulus  = m;
      bus8.go       = 1'b1;
   endtask

   task automatic wait8(output int cyc, output bit to);
      cyc = 0;
      to  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bus8.done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic run8(input logic [7:0] msg, input logic [7:0] e, input logic [7:0] m,
                       input string name);
      int cyc;
      bit to;
      longint unsigned exp_c;
      bit exp_err;
      start8(msg, e, m);
      wait8(cyc, to);
      bus8.go = 1'b0;
      exp_c   = ref_pow(msg, e, m);
      exp_err = (m < 2 || msg >= m);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: done never rose", name);
      end else begin
         if (bus8.cypher !== exp_c[7:0] || bus8.err !== exp_err) begin
            errors++;
            $display("FAIL %s result: cypher=%0d err=%0b, want cypher=%0d err=%0b", name,
                     bus8.cypher, bus8.err, exp_c, exp_err);
         end
         checks++;
         if (cyc != ref_lat(msg, e, m, 8, 8)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, ref_lat(msg, e, m, 8, 8));
         end
      end
   endtask

   task automatic run32(input logic [31:0] msg, input logic [23:0] e, input logic [31:0] m,
                        input string name);
      int cyc;
      bit to;
      longint unsigned exp_c;
      @(negedge clk);
      bus32.go = 1'b0;
      @(negedge clk);
      bus32.message  = msg;
      bus32.exponent = e;
      bus32.modulus  = m;
      bus32.go       = 1'b1;
      cyc = 0;
      to  = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (bus32.done) begin
            to = 1'b0;
            break;
         end
      end
      bus32.go = 1'b0;
      exp_c    = ref_pow(msg, e, m);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: done never rose", name);
      end else begin
         if (bus32.cypher !== exp_c[31:0] || bus32.err !== (m < 2 || msg >= m)) begin
            errors++;
            $display("FAIL %s result: cypher=%0h err=%0b, want cypher=%0h", name,
                     bus32.cypher, bus32.err, exp_c);
         end
         checks++;
         if (cyc != ref_lat(msg, e, m, 32, 24)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc,
                     ref_lat(msg, e, m, 32, 24));
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus8.done, bus8.busy, bus8.err, bus8.cypher} !== 11'd0 ||
          {bus32.done, bus32.busy, bus32.err, bus32.cypher} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: dut8 d/b/e/c=%b%b%b/%0d dut32 c=%0h, want all zero",
                  bus8.done, bus8.busy, bus8.err, bus8.cypher, bus32.cypher);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      run8(8'd8, 8'd13, 8'd77, "encrypt_8_13_77");
      checks++;
      if (bus8.cypher !== 8'd50 || bus8.done !== 1'b1) begin
         errors++;
         $display("FAIL encrypt_const: cypher=%0d done=%b want 50/1", bus8.cypher, bus8.done);
      end
      run8(8'd50, 8'd37, 8'd77, "decrypt_50_37_77");
      checks++;
      if (bus8.cypher !== 8'd8) begin
         errors++;
         $display("FAIL round_trip: cypher=%0d want 8", bus8.cypher);
      end
   endtask

   task automatic test_edge_cases;
      run8(8'd9, 8'd0, 8'd77, "exp_zero");
      run8(8'd0, 8'd5, 8'd1, "mod_one");
      run8(8'd80, 8'd5, 8'd77, "msg_ge_mod");
      run8(8'd0, 8'd5, 8'd77, "msg_zero");
      run8(8'd254, 8'd255, 8'd255, "max_operands");
   endtask

   task automatic test_go_hold_and_busy_edge;
      bit saw_busy;
      int cyc;
      bit to;
      start8(8'd8, 8'd13, 8'd77);
      wait8(cyc, to);
      saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus8.busy) saw_busy = 1'b1;
      end
      checks++;
      if (to || saw_busy !== 1'b0 || bus8.cypher !== 8'd50) begin
         errors++;
         $display("FAIL go_held: timeout=%b busy_seen=%b cypher=%0d want 0/0/50", to, saw_busy,
                  bus8.cypher);
      end
      start8(8'd8, 8'd13, 8'd77);
      repeat (10) @(negedge clk);
      bus8.go      = 1'b0;
      bus8.message = 8'd2;
      repeat (2) @(negedge clk);
      bus8.go = 1'b1;
      wait8(cyc, to);
      bus8.go = 1'b0;
      checks++;
      if (to || bus8.cypher !== 8'd50 || bus8.err !== 1'b0) begin
         errors++;
         $display("FAIL go_while_busy: timeout=%b cypher=%0d err=%b want 0/50/0", to,
                  bus8.cypher, bus8.err);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b1) begin
         errors++;
         $display("FAIL no_restart: busy=%b done=%b want 0/1", bus8.busy, bus8.done);
      end
   endtask

   task automatic test_abort_and_reset;
      start8(8'd8, 8'd13, 8'd77);
      repeat (20) @(negedge clk);
      bus8.go    = 1'b0;
      bus8.abort = 1'b1;
      @(negedge clk);
      bus8.abort = 1'b0;
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.err !== 1'b0 ||
          bus8.cypher !== 8'd0) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b err=%b cypher=%0d want 0/0/0/0", bus8.busy,
                  bus8.done, bus8.err, bus8.cypher);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b done=%b want 0/0", bus8.busy, bus8.done);
      end
      run8(8'd8, 8'd13, 8'd77, "after_abort");
      start8(8'd8, 8'd13, 8'd77);
      repeat (15) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.err !== 1'b0 ||
          bus8.cypher !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b err=%b cypher=%0d want all 0", bus8.busy,
                  bus8.done, bus8.err, bus8.cypher);
      end
      bus8.go = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random8;
      for (int i = 0; i < 8; i++) begin
         run8(8'($urandom), 8'($urandom), 8'($urandom_range(255, 2)), "random8");
      end
   endtask

   task automatic test_wide;
      logic [31:0] m, msg;
      m   = 32'hC2D4_6E1B;
      msg = 32'h1234_5678;
      run32(msg, 24'hF3E7AF, m, "wide_golden");
      for (int i = 0; i < 6; i++) begin
         m = $urandom & 32'hFFFF_FFFE;
         if (m < 32'd2) m = 32'd2;
         msg = $urandom % m;
         run32(msg, 24'($urandom), m, "wide_even_random");
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset          = 1'b1;
      bus8.go        = 1'b0;
      bus8.abort     = 1'b0;
      bus8.message   = '0;
      bus8.exponent  = '0;
      bus8.modulus   = '0;
      bus32.go       = 1'b0;
      bus32.abort    = 1'b0;
      bus32.message  = '0;
      bus32.exponent = '0;
      bus32.modulus  = '0;
      test_reset();
      test_basic();
      test_edge_cases();
      test_go_hold_and_busy_edge();
      test_abort_and_reset();
      test_random8();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
